// File: rtl/led_effect.sv
// LED effect engine: per-LED blink masking and global PWM dimming applied to
// the raw LED image before it is registered onto the board pins. A small
// four-register bus interface holds control, blink half-period and blink mask.
module led_effect #(
  parameter int TICK_DIV  = 23000,
  parameter int BLINK_RST = 500
) (
  input  logic        led_clk,
  input  logic        ledrst,
  input  logic        effcs,
  input  logic        effwrite,
  input  logic [1:0]  effaddr,
  input  logic [15:0] effwdata,
  output logic [15:0] effrdata,
  input  logic [23:0] ledin,
  output logic [23:0] ledpin
);

  localparam int              PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [15:0]     BLINK_RST_V = 16'(BLINK_RST);

  typedef enum logic [1:0] {
    ADDR_CTRL    = 2'b00,
    ADDR_HALF    = 2'b01,
    ADDR_MASK_LO = 2'b10,
    ADDR_MASK_HI = 2'b11
  } reg_addr_e;

  // Register file
  logic        r_blink_en;
  logic        r_dim_en;
  logic [7:0]  r_duty;
  logic [15:0] r_blink_half;
  logic [23:0] r_mask;

  // Timing state
  logic [PW-1:0] r_presc;
  logic [15:0]   r_blink_cnt;
  logic          r_phase;
  logic [7:0]    r_pwm_cnt;
  logic [23:0]   r_ledpin;

  // Decoded write strobes
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_half;
  logic        w_wr_mask_lo;
  logic        w_wr_mask_hi;
  logic        w_tick;
  logic        w_pwm_on;
  logic [23:0] w_blink_ok;
  logic        w_dim_ok;
  logic [23:0] w_led_next;

  assign w_wr         = effcs & effwrite;
  assign w_wr_ctrl    = w_wr & (effaddr == ADDR_CTRL);
  assign w_wr_half    = w_wr & (effaddr == ADDR_HALF);
  assign w_wr_mask_lo = w_wr & (effaddr == ADDR_MASK_LO);
  assign w_wr_mask_hi = w_wr & (effaddr == ADDR_MASK_HI);

  // Bus register writes; CTRL bits [7:2] are not stored
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      r_blink_en   <= 1'b0;
      r_dim_en     <= 1'b0;
      r_duty       <= 8'h00;
      r_blink_half <= BLINK_RST_V;
      r_mask       <= 24'h000000;
    end else begin
      if (w_wr_ctrl) begin
        r_blink_en <= effwdata[0];
        r_dim_en   <= effwdata[1];
        r_duty     <= effwdata[15:8];
      end
      if (w_wr_half)    r_blink_half  <= effwdata;
      if (w_wr_mask_lo) r_mask[15:0]  <= effwdata;
      if (w_wr_mask_hi) r_mask[23:16] <= effwdata[7:0];
    end
  end

  // Combinational readback of the addressed register, independent of effcs
  // NOTE: every output of this block gets a default first so no latch can form.
  always_comb begin
    effrdata = 16'h0000;
    case (reg_addr_e'(effaddr))
      ADDR_CTRL:    effrdata = {r_duty, 6'b000000, r_dim_en, r_blink_en};
      ADDR_HALF:    effrdata = r_blink_half;
      ADDR_MASK_LO: effrdata = r_mask[15:0];
      ADDR_MASK_HI: effrdata = {8'h00, r_mask[23:16]};
      default:      effrdata = 16'h0000;
    endcase
  end

  assign w_tick = (r_presc == PRESC_MAX);

  // Free-running tick prescaler; bus writes never disturb it
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Blink half-period counter and phase; a BLINK_HALF write restarts the
  // period with the LEDs visible and wins over a coincident tick
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      r_blink_cnt <= 16'h0000;
      r_phase     <= 1'b1;
    end else if (w_wr_half || (r_blink_half == 16'h0000)) begin
      r_blink_cnt <= 16'h0000;
      r_phase     <= 1'b1;
    end else if (w_tick) begin
      if (r_blink_cnt == r_blink_half - 16'd1) begin
        r_blink_cnt <= 16'h0000;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end

  // Free-running 8-bit PWM counter, wraps 255 -> 0
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) r_pwm_cnt <= 8'h00;
    else        r_pwm_cnt <= r_pwm_cnt + 8'd1;
  end

  assign w_pwm_on   = (r_pwm_cnt < r_duty);
  assign w_blink_ok = ~{24{r_blink_en}} | ~r_mask | {24{r_phase}};
  assign w_dim_ok   = ~r_dim_en | w_pwm_on;
  assign w_led_next = ledin & w_blink_ok & {24{w_dim_ok}};

  // Registered pin drive; reset blanks the pins immediately
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) r_ledpin <= 24'h000000;
    else        r_ledpin <= w_led_next;
  end

  assign ledpin = r_ledpin;

endmodule

// File: tb/tb_led_effect.sv
// Directed bench for led_effect with a short tick (TICK_DIV=4). Inputs change
// on the falling edge; outputs are sampled on the falling edge.
module tb_led_effect;

  logic        led_clk = 1'b0;
  logic        ledrst  = 1'b1;
  logic        effcs   = 1'b0;
  logic        effwrite = 1'b0;
  logic [1:0]  effaddr = 2'b00;
  logic [15:0] effwdata = 16'h0000;
  logic [15:0] effrdata;
  logic [23:0] ledin = 24'h000000;
  logic [23:0] ledpin;

  int total = 0;
  int bad   = 0;

  led_effect #(.TICK_DIV(4), .BLINK_RST(500)) dut (
    .led_clk  (led_clk),
    .ledrst   (ledrst),
    .effcs    (effcs),
    .effwrite (effwrite),
    .effaddr  (effaddr),
    .effwdata (effwdata),
    .effrdata (effrdata),
    .ledin    (ledin),
    .ledpin   (ledpin)
  );

  always #5 led_clk = ~led_clk;

  task automatic set_bus(input logic [1:0] a, input logic [15:0] d);
    effcs = 1'b1; effwrite = 1'b1; effaddr = a; effwdata = d;
  endtask

  task automatic idle_bus();
    effcs = 1'b0; effwrite = 1'b0; effwdata = 16'h0000;
  endtask

  // One write on the rising edge between two falling edges
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge led_clk);
    set_bus(a, d);
    @(negedge led_clk);
    idle_bus();
  endtask

  task automatic test_reset();
    ledrst = 1'b1;
    repeat (3) @(negedge led_clk);
    total++;
    if (ledpin !== 24'h000000) begin
      bad++; $display("FAIL reset_ledpin got=%h want=000000", ledpin);
    end
    effaddr = 2'b01; #1;
    total++;
    if (effrdata !== 16'h01F4) begin
      bad++; $display("FAIL reset_half got=%h want=01f4", effrdata);
    end
    ledrst = 1'b0;
    @(negedge led_clk);
  endtask

  task automatic test_passthrough();
    ledin = 24'hA5A5A5;
    effaddr = 2'b00;
    @(negedge led_clk);
    total++;
    if (ledpin !== 24'hA5A5A5) begin
      bad++; $display("FAIL pass_ledpin got=%h want=a5a5a5", ledpin);
    end
    total++;
    if (effrdata !== 16'h0000) begin
      bad++; $display("FAIL pass_ctrl_rd got=%h want=0000", effrdata);
    end
  endtask

  task automatic test_readback();
    bus_write(2'b00, 16'hFFFF);
    effaddr = 2'b00; #1;
    total++;
    if (effrdata !== 16'hFF03) begin
      bad++; $display("FAIL rd_ctrl got=%h want=ff03", effrdata);
    end
    bus_write(2'b11, 16'hABCD);
    effaddr = 2'b11; #1;
    total++;
    if (effrdata !== 16'h00CD) begin
      bad++; $display("FAIL rd_mask_hi got=%h want=00cd", effrdata);
    end
    // Write with effcs low must not land
    @(negedge led_clk);
    effcs = 1'b0; effwrite = 1'b1; effaddr = 2'b10; effwdata = 16'h1234;
    @(negedge led_clk);
    idle_bus(); #1;
    total++;
    if (effrdata !== 16'h0000) begin
      bad++; $display("FAIL rd_no_cs got=%h want=0000", effrdata);
    end
    bus_write(2'b00, 16'h0000);
    bus_write(2'b11, 16'h0000);
  endtask

  task automatic test_blink();
    logic [23:0] smp [48];
    int last_t, n_t, bad_len, bad_val;
    bus_write(2'b10, 16'h00FF);
    bus_write(2'b11, 16'h0000);
    bus_write(2'b01, 16'h0002);
    bus_write(2'b00, 16'h0001);
    ledin = 24'hFFFFFF;
    @(negedge led_clk);
    for (int i = 0; i < 48; i++) begin
      @(negedge led_clk);
      smp[i] = ledpin;
    end
    last_t = -1; n_t = 0; bad_len = 0; bad_val = 0;
    for (int i = 0; i < 48; i++) begin
      if (smp[i] !== 24'hFFFFFF && smp[i] !== 24'hFFFF00) bad_val++;
      if (i > 0 && smp[i] !== smp[i-1]) begin
        if (last_t >= 0 && (i - last_t) != 8) bad_len++;
        last_t = i;
        n_t++;
      end
    end
    total++;
    if (bad_val != 0) begin
      bad++; $display("FAIL blink_levels got=%0d bad samples want=0", bad_val);
    end
    total++;
    if (n_t < 4) begin
      bad++; $display("FAIL blink_toggles got=%0d want>=4", n_t);
    end
    total++;
    if (bad_len != 0) begin
      bad++; $display("FAIL blink_period got=%0d bad runs want=0 (run=8)", bad_len);
    end
  endtask

  task automatic dim_count(input logic [15:0] ctrl, input int want, input string nm);
    int on_cnt, other;
    bus_write(2'b00, ctrl);
    ledin = 24'h000001;
    repeat (2) @(negedge led_clk);
    on_cnt = 0; other = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge led_clk);
      if (ledpin[0] === 1'b1) on_cnt++;
      if (ledpin[23:1] !== 23'h0) other++;
    end
    total++;
    if (on_cnt != want || other != 0) begin
      bad++; $display("FAIL %s got=%0d on (%0d stray) want=%0d", nm, on_cnt, other, want);
    end
  endtask

  task automatic test_dim();
    dim_count(16'h4002, 64,  "dim_duty64");
    dim_count(16'h0002, 0,   "dim_duty0");
    dim_count(16'hFF02, 255, "dim_duty255");
  endtask

  task automatic test_half_zero();
    logic [23:0] prev;
    int errs;
    bus_write(2'b10, 16'hFFFF);
    bus_write(2'b11, 16'h00FF);
    bus_write(2'b01, 16'h0000);
    bus_write(2'b00, 16'h0001);
    errs = 0;
    prev = 24'h5A3C96;
    ledin = prev;
    for (int i = 0; i < 40; i++) begin
      @(negedge led_clk);
      if (ledpin !== prev) errs++;
      prev = {prev[22:0], prev[23]} ^ 24'h010203;
      ledin = prev;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL half0_pass got=%0d errors want=0", errs);
    end
  endtask

  // Edges are counted from reset release: ticks land on edges 4, 8, 12, ...
  task automatic test_back_to_back_half_write();
    ledin = 24'hFFFFFF;
    @(negedge led_clk); ledrst = 1'b1;
    @(negedge led_clk); ledrst = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      case (e)
        1:  set_bus(2'b10, 16'hFFFF);
        2:  set_bus(2'b11, 16'h00FF);
        3:  set_bus(2'b00, 16'h0001);
        4:  set_bus(2'b01, 16'h0001);
        16: set_bus(2'b01, 16'h0001);
        default: idle_bus();
      endcase
      @(negedge led_clk);
      idle_bus();
      if (e == 8) begin
        total++;
        if (ledpin !== 24'hFFFFFF) begin
          bad++; $display("FAIL tick_e8 got=%h want=ffffff", ledpin);
        end
      end
      if (e == 9) begin
        total++;
        if (ledpin !== 24'h000000) begin
          bad++; $display("FAIL tick_e9 got=%h want=000000", ledpin);
        end
      end
      if (e == 13) begin
        total++;
        if (ledpin !== 24'hFFFFFF) begin
          bad++; $display("FAIL tick_e13 got=%h want=ffffff", ledpin);
        end
      end
      if (e == 17) begin
        total++;
        if (ledpin !== 24'hFFFFFF) begin
          bad++; $display("FAIL write_vs_tick got=%h want=ffffff", ledpin);
        end
      end
      if (e == 21) begin
        total++;
        if (ledpin !== 24'h000000) begin
          bad++; $display("FAIL after_write_tick got=%h want=000000", ledpin);
        end
      end
    end
  endtask

  // Continues from phase=0 left by the previous scenario
  task automatic test_reset_mid_blink();
    #2 ledrst = 1'b1;
    #1;
    total++;
    if (ledpin !== 24'h000000) begin
      bad++; $display("FAIL rst_async_ledpin got=%h want=000000", ledpin);
    end
    effaddr = 2'b00; #1;
    total++;
    if (effrdata !== 16'h0000) begin
      bad++; $display("FAIL rst_ctrl got=%h want=0000", effrdata);
    end
    effaddr = 2'b01; #1;
    total++;
    if (effrdata !== 16'h01F4) begin
      bad++; $display("FAIL rst_half got=%h want=01f4", effrdata);
    end
    effaddr = 2'b10; #1;
    total++;
    if (effrdata !== 16'h0000) begin
      bad++; $display("FAIL rst_mask_lo got=%h want=0000", effrdata);
    end
    effaddr = 2'b11; #1;
    total++;
    if (effrdata !== 16'h0000) begin
      bad++; $display("FAIL rst_mask_hi got=%h want=0000", effrdata);
    end
    @(negedge led_clk); ledrst = 1'b0;
    bus_write(2'b10, 16'hFFFF);
    bus_write(2'b11, 16'h00FF);
    bus_write(2'b00, 16'h0001);
    @(negedge led_clk);
    total++;
    if (ledpin !== 24'hFFFFFF) begin
      bad++; $display("FAIL rst_phase got=%h want=ffffff", ledpin);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_readback();
    test_blink();
    test_dim();
    test_half_zero();
    test_back_to_back_half_write();
    test_reset_mid_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
